// File: rtl/tetris_move_gen_if.sv
// Bundle between the controller reader / piece logic and tetris_move_gen.
// Handshake: buttons_valid is a one-cycle sample strobe with no back-pressure.
// A command transfers on every rising clk edge where cmd_valid and cmd_ready
// are both high. While cmd_valid is high and cmd_ready is low, cmd holds.
interface tetris_move_gen_if;
  logic [7:0] buttons;
  logic       buttons_valid;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       paused;

  modport master (
    output buttons,
    output buttons_valid,
    output cmd_ready,
    input  cmd,
    input  cmd_valid,
    input  paused
  );

  modport slave (
    input  buttons,
    input  buttons_valid,
    input  cmd_ready,
    output cmd,
    output cmd_valid,
    output paused
  );
endinterface

// File: rtl/tetris_move_gen.sv
// Debounces NES button samples, generates press/auto-repeat game commands,
// queues them in a coalescing pending mask and emits one per transfer in
// fixed priority order. All parameters must fit in 8 bits.
module tetris_move_gen #(
  parameter int DEBOUNCE  = 2,
  parameter int DAS_DELAY = 16,
  parameter int DAS_RATE  = 6,
  parameter int DROP_RATE = 3
) (
  input logic              clk,
  input logic              reset,
  tetris_move_gen_if.slave io
);
  localparam logic [7:0] DBN    = 8'(DEBOUNCE);
  localparam logic [7:0] DAS_D  = 8'(DAS_DELAY);
  localparam logic [7:0] DAS_R  = 8'(DAS_RATE);
  localparam logic [7:0] DROP_R = 8'(DROP_RATE);

  // Button bit positions in the raw vector.
  localparam int B_A     = 7;
  localparam int B_B     = 6;
  localparam int B_START = 4;
  localparam int B_UP    = 3;
  localparam int B_DOWN  = 2;
  localparam int B_LEFT  = 1;
  localparam int B_RIGHT = 0;

  // Command codes, which double as pending-mask bit positions.
  localparam int C_LEFT  = 0;
  localparam int C_RIGHT = 1;
  localparam int C_SOFT  = 2;
  localparam int C_HARD  = 3;
  localparam int C_CW    = 4;
  localparam int C_CCW   = 5;
  localparam int C_PAUSE = 6;

  logic [7:0] stable_q, stable_d;
  logic [7:0] db_cnt_q [8];
  logic [7:0] db_cnt_d [8];
  logic [7:0] left_cnt_q, left_cnt_d;
  logic [7:0] right_cnt_q, right_cnt_d;
  logic [7:0] down_cnt_q, down_cnt_d;
  logic       paused_q, paused_d;
  logic [6:0] pend_q, pend_d;
  logic [2:0] cmd_q, cmd_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [6:0] ev;
  logic       load;
  logic [2:0] pick;

  // One repeat step for a held direction: returns {event, next counter}.
  // A counter of 0 while held means repeating is idle (e.g. held across pause).
  function automatic logic [8:0] das_step(
    input logic       held,
    input logic       press,
    input logic       other_released,
    input logic [7:0] cnt,
    input logic [7:0] load_v,
    input logic [7:0] reload_v
  );
    if (!held)                return {1'b0, 8'd0};
    else if (press)           return {1'b1, load_v};
    else if (other_released)  return {1'b0, load_v};
    else if (cnt == 8'd1)     return {1'b1, reload_v};
    else if (cnt != 8'd0)     return {1'b0, cnt - 8'd1};
    else                      return {1'b0, 8'd0};
  endfunction

  // Highest-priority pending command.
  function automatic logic [2:0] pick_cmd(input logic [6:0] p);
    if (p[C_PAUSE])     return 3'(C_PAUSE);
    else if (p[C_HARD]) return 3'(C_HARD);
    else if (p[C_CW])   return 3'(C_CW);
    else if (p[C_CCW])  return 3'(C_CCW);
    else if (p[C_LEFT]) return 3'(C_LEFT);
    else if (p[C_RIGHT]) return 3'(C_RIGHT);
    else                return 3'(C_SOFT);
  endfunction

  // Per-button debounce counters; they only move on sample strobes.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    if (io.buttons_valid) begin
      for (int i = 0; i < 8; i++) begin
        if (io.buttons[i] != stable_q[i]) begin
          if (db_cnt_q[i] + 8'd1 == DBN) begin
            stable_d[i] = io.buttons[i];
            db_cnt_d[i] = 8'd0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 8'd1;
          end
        end else begin
          db_cnt_d[i] = 8'd0;
        end
      end
    end
  end

  logic press_a, press_b, press_start, press_up, press_down, press_left, press_right;
  logic left_held, right_held, left_gone, right_gone;
  logic [8:0] l_step, r_step, d_step;

  assign press_a     = stable_d[B_A]     & ~stable_q[B_A];
  assign press_b     = stable_d[B_B]     & ~stable_q[B_B];
  assign press_start = stable_d[B_START] & ~stable_q[B_START];
  assign press_up    = stable_d[B_UP]    & ~stable_q[B_UP];
  assign press_down  = stable_d[B_DOWN]  & ~stable_q[B_DOWN];
  assign press_left  = stable_d[B_LEFT]  & ~stable_q[B_LEFT];
  assign press_right = stable_d[B_RIGHT] & ~stable_q[B_RIGHT];
  assign left_held   = stable_d[B_LEFT];
  assign right_held  = stable_d[B_RIGHT];
  // The opposite direction dropping out restarts the survivor at DAS_DELAY.
  assign left_gone   = stable_q[B_LEFT]  & ~stable_d[B_LEFT];
  assign right_gone  = stable_q[B_RIGHT] & ~stable_d[B_RIGHT];

  assign l_step = das_step(left_held, press_left, right_gone, left_cnt_q, DAS_D, DAS_R);
  assign r_step = das_step(right_held, press_right, left_gone, right_cnt_q, DAS_D, DAS_R);
  assign d_step = das_step(stable_d[B_DOWN], press_down, 1'b0, down_cnt_q, DROP_R, DROP_R);

  // Event generation, pause toggling and repeat counters for this sample.
  always_comb begin
    ev          = '0;
    left_cnt_d  = left_cnt_q;
    right_cnt_d = right_cnt_q;
    down_cnt_d  = down_cnt_q;
    paused_d    = paused_q ^ press_start;
    ev[C_PAUSE] = press_start;
    if (io.buttons_valid) begin
      if (paused_d) begin
        left_cnt_d  = 8'd0;
        right_cnt_d = 8'd0;
        down_cnt_d  = 8'd0;
      end else begin
        ev[C_HARD] = press_up;
        ev[C_CW]   = press_a;
        ev[C_CCW]  = press_b;
        if (left_held && right_held) begin
          left_cnt_d  = DAS_D;
          right_cnt_d = DAS_D;
        end else begin
          ev[C_LEFT]  = l_step[8];
          left_cnt_d  = l_step[7:0];
          ev[C_RIGHT] = r_step[8];
          right_cnt_d = r_step[7:0];
        end
        ev[C_SOFT] = d_step[8];
        down_cnt_d = d_step[7:0];
      end
    end
  end

  assign load = !cmd_valid_q || io.cmd_ready;
  assign pick = pick_cmd(pend_q);

  // Output register reload and pending-mask update; new events are OR-ed in
  // last so one landing on the bit being drained is kept.
  always_comb begin
    pend_d      = pend_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    if (load) begin
      cmd_valid_d = |pend_q;
      if (|pend_q) begin
        cmd_d  = pick;
        pend_d = pend_d & ~(7'b1 << pick);
      end
    end
    if (press_start && !paused_q) begin
      pend_d[5:0] = '0;
    end
    pend_d = pend_d | ev;
  end

  // Input-side state: debounce, repeat counters, pause flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q    <= '0;
      for (int i = 0; i < 8; i++) db_cnt_q[i] <= '0;
      left_cnt_q  <= '0;
      right_cnt_q <= '0;
      down_cnt_q  <= '0;
      paused_q    <= 1'b0;
    end else begin
      stable_q    <= stable_d;
      for (int i = 0; i < 8; i++) db_cnt_q[i] <= db_cnt_d[i];
      left_cnt_q  <= left_cnt_d;
      right_cnt_q <= right_cnt_d;
      down_cnt_q  <= down_cnt_d;
      paused_q    <= paused_d;
    end
  end

  // Output-side state: pending mask and command register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q      <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign io.cmd       = cmd_q;
  assign io.cmd_valid = cmd_valid_q;
  assign io.paused    = paused_q;
endmodule

// File: doc/tetris_move_gen.md
# tetris_move_gen

Converts the per-frame 8-bit button vector produced by the NES controller reader into debounced, auto-repeating game commands for the Tetris core. It sits directly downstream of the input controller and upstream of the piece-movement logic. Commands leave through a valid/ready handshake, one per transfer, in fixed priority order.

## Interface
- DEBOUNCE, 2: consecutive differing samples required to change a debounced button state (1 = no filtering).
- DAS_DELAY, 16: samples from Left/Right press to first repeat.
- DAS_RATE, 6: samples between subsequent Left/Right repeats.
- DROP_RATE, 3: samples from Down press to first repeat, and between Down repeats.
- clk  input  1  system clock, 40 MHz.
- reset  input  1  asynchronous, active-low reset.
- buttons  input  8  raw button states, active-high; bit 7..0 = A, B, Select, Start, Up, Down, Left, Right.
- buttons_valid  input  1  one-cycle strobe; `buttons` is sampled only on cycles where it is high (one per controller poll).
- cmd  output  3  command code: 0 left, 1 right, 2 soft_drop, 3 hard_drop, 4 rotate_cw, 5 rotate_ccw, 6 pause_toggle.
- cmd_valid  output  1  `cmd` holds a command.
- cmd_ready  input  1  consumer accepts `cmd` when `cmd_valid` and `cmd_ready` are both high.
- paused  output  1  game-paused flag.

## Operation
- Reset: debounced states 0, repeat counters 0, pending mask 0, `cmd` = 0, `cmd_valid` = 0, `paused` = 0.
- Debounce, per button, evaluated only on sample edges: a per-button counter increments while raw differs from stable and clears when they match. When the counter reaches DEBOUNCE, stable takes the raw value and the counter clears.
- Press event: a debounced 0→1 transition. Select is ignored.
- Event sources:
  - A → rotate_cw.
  - B → rotate_ccw.
  - Up → hard_drop.
  - Start → pause_toggle.
  - These four generate events on press only.
- Left and Right:
  - Press gives an event and loads the counter with DAS_DELAY.
  - On each later sample while held, if counter == 1, give an event and reload DAS_RATE; otherwise decrement.
  - Release clears the counter.
- Down: same repeat scheme, using DROP_RATE for both the load and the reload.
- Left and Right both stably held: no left/right events; both counters are forced to DAS_DELAY. When one is released, the other resumes counting from DAS_DELAY without an immediate event.
- Pause:
  - A Start event toggles `paused` on the same sample edge and sets the pending pause bit.
  - While `paused` = 1, all other events are discarded and their repeat counters are held at 0.
  - Entering pause also clears all non-pause pending bits.
- Pending mask: 7 bits, one per command code. Events are OR-ed in, so a duplicate of an already-pending command coalesces.
- Output register:
  - Loads on any cycle where it is empty, or where a transfer completes.
  - It takes the highest-priority pending bit and clears that bit.
  - Priority: pause_toggle > hard_drop > rotate_cw > rotate_ccw > left > right > soft_drop.
- If the output is empty and the mask is empty, `cmd_valid` is 0.
- `cmd` is held stable while `cmd_valid` = 1 and `cmd_ready` = 0.

## Timing
- Sample edge E0 (`buttons_valid` = 1): debounce/repeat state updates and events are written into the pending mask.
- Edge E1: the output register loads, so `cmd_valid` is high in the cycle after E1. With DEBOUNCE = 1, a press therefore produces `cmd_valid` 2 edges after it is sampled.
- Back-to-back throughput: one command per clock while `cmd_ready` = 1.
- An event arriving on the same edge that clears the same pending bit into the output stays set, so it is not lost.
- Events from sample N are fully drained within 7 cycles when `cmd_ready` = 1. This is far below the poll period.
- `buttons_valid` strobes closer together than 8 cycles are legal; coalescing bounds storage.
- Reset asserted mid-transfer drops `cmd_valid` immediately (asynchronous) and discards all pending commands.

## Test plan
- DEBOUNCE = 2, hold A for 4 samples → exactly one cmd = 4, appearing after the 2nd sample edge + 1 clock; a 1-sample glitch on B → no command.
- Hold Left for 30 samples, DEBOUNCE = 1, `cmd_ready` = 1 → cmd = 0 on samples 1, 17, 23, 29 (4 commands total).
- Same sample presses A, Up and Right, `cmd_ready` = 1 → cmd sequence 3, 4, 1 on three consecutive cycles.
- `cmd_ready` held 0 for 10 cycles with cmd = 2 valid → `cmd` stable at 2; a repeated Down event coalesces; a single further cmd = 2 follows once ready rises.
- Press Start, then press A and Left while paused → cmd = 6 and `paused` = 1; no other commands. A second Start → cmd = 6 and `paused` = 0.
- Hold Left + Right together for 20 samples → no left/right commands. Release Right → next cmd = 0 arrives DAS_DELAY samples later. Assert reset during the wait → `cmd_valid` = 0 and `paused` = 0 immediately.
